// File: rtl/noc_packet_collector.sv
// Captures newly valid router outputs, queues them round-robin into a small FIFO
// and shows the popped entry (router index, payload) on two 7-segment digits.
module noc_packet_collector #(
  parameter int NODES      = 81,
  parameter int PKT_W      = 15,
  parameter int IDX_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NODES*PKT_W-1:0]      in_router,
  input  logic                        key_next,
  output logic                        disp_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  pkt_count,
  output logic                        lost_flag,
  output logic [6:0]                  hex_data,
  output logic [6:0]                  hex_router
);

  localparam int PAY_W = PKT_W - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + PAY_W;
  localparam logic [IDX_W:0]   NODES_C = (IDX_W+1)'(NODES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [6:0]       BLANK   = 7'b1111111;

  logic [NODES*PKT_W-1:0] in_q, in_q2;
  logic [NODES-1:0]       pend_q, pend_d, arrival;
  logic [PAY_W-1:0]       pay_q [NODES];
  logic [PAY_W-1:0]       pay_d [NODES];
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [7:0]             pkt_cnt_q, pkt_cnt_d;
  logic                   lost_q, lost_d;
  logic                   key_q;
  logic                   disp_valid_q, disp_valid_d;
  logic [ENT_W-1:0]       disp_ent_q, disp_ent_d;
  logic [6:0]             hex_data_q, hex_data_d, hex_router_q, hex_router_d;

  logic             pop_req, pop, full, grant, gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   cand;
  logic             unused_bits;

  function automatic logic [6:0] seg7(input logic [6:0] v);
    case (v)
      7'd0:    return ~7'b1111110;
      7'd1:    return ~7'b0110000;
      7'd2:    return ~7'b1101101;
      7'd3:    return ~7'b1111001;
      7'd4:    return ~7'b0110011;
      7'd5:    return ~7'b1011011;
      7'd6:    return ~7'b1011111;
      7'd7:    return ~7'b1110000;
      7'd8:    return ~7'b1111111;
      7'd9:    return ~7'b1111011;
      default: return ~7'b0000001;
    endcase
  endfunction

  assign pop_req = key_next & ~key_q;
  assign pop     = pop_req & (count_q != '0);
  assign full    = (count_q == DEPTH_C);
  assign grant   = gnt_found & (~full | pop);

  // Round-robin search starting at rr_q, wrapping modulo NODES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NODES; k++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (cand >= NODES_C) cand = cand - NODES_C;
      if (!gnt_found && pend_q[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (gnt_idx == IDX_W'(NODES - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // An arrival on a slot still pending after this cycle's grant overwrites it.
  always_comb begin
    pend_d  = pend_q;
    lost_d  = lost_q;
    arrival = '0;
    for (int i = 0; i < NODES; i++) begin
      pay_d[i]   = pay_q[i];
      arrival[i] = in_q[i*PKT_W + PKT_W - 1] & ~in_q2[i*PKT_W + PKT_W - 1];
      if (grant && gnt_idx == IDX_W'(i)) pend_d[i] = 1'b0;
      if (arrival[i]) begin
        if (pend_d[i]) lost_d = 1'b1;
        pend_d[i] = 1'b1;
        pay_d[i]  = in_q[i*PKT_W +: PAY_W];
      end
    end
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    disp_valid_d = disp_valid_q;
    disp_ent_d   = disp_ent_q;
    count_d      = count_q + CNT_W'(grant) - CNT_W'(pop);
    if (grant) begin
      mem_d[wr_ptr_q] = {gnt_idx, pay_q[gnt_idx]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (pkt_cnt_q != 8'd255) pkt_cnt_d = pkt_cnt_q + 8'd1;
    end
    if (pop) begin
      disp_ent_d   = mem_q[rd_ptr_q];
      disp_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    hex_data_d   = BLANK;
    hex_router_d = BLANK;
    if (disp_valid_q) begin
      hex_data_d   = seg7(disp_ent_q[6:0]);
      hex_router_d = seg7(7'(disp_ent_q[ENT_W-1 -: IDX_W]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q         <= '0;
      in_q2        <= '0;
      pend_q       <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_cnt_q    <= '0;
      lost_q       <= 1'b0;
      key_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_ent_q   <= '0;
      hex_data_q   <= BLANK;
      hex_router_q <= BLANK;
      for (int i = 0; i < NODES; i++) pay_q[i] <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= '0;
    end else begin
      in_q         <= in_router;
      in_q2        <= in_q;
      pend_q       <= pend_d;
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_cnt_q    <= pkt_cnt_d;
      lost_q       <= lost_d;
      key_q        <= key_next;
      disp_valid_q <= disp_valid_d;
      disp_ent_q   <= disp_ent_d;
      hex_data_q   <= hex_data_d;
      hex_router_q <= hex_router_d;
      for (int i = 0; i < NODES; i++) pay_q[i] <= pay_d[i];
      for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= mem_d[e];
    end
  end

  // Upper payload bits travel with the packet but never reach a digit.
  assign unused_bits = ^disp_ent_q[PAY_W-1:7];

  assign disp_valid = disp_valid_q;
  assign fifo_count = count_q;
  assign pkt_count  = pkt_cnt_q;
  assign lost_flag  = lost_q;
  assign hex_data   = hex_data_q;
  assign hex_router = hex_router_q;

endmodule

// File: tb/tb_noc_packet_collector.sv
// Bench for noc_packet_collector: directed scenarios plus random traffic, all
// compared against a queue-based behavioural model of the collector.
module tb_noc_packet_collector;

  localparam int NODES      = 81;
  localparam int PKT_W      = 15;
  localparam int IDX_W      = 7;
  localparam int FIFO_DEPTH = 4;
  localparam logic [6:0] DASH  = ~7'b0000001;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NODES*PKT_W-1:0] in_router = '0;
  logic                   key_next = 1'b0;
  logic                   disp_valid;
  logic [2:0]             fifo_count;
  logic [7:0]             pkt_count;
  logic                   lost_flag;
  logic [6:0]             hex_data, hex_router;
  logic [26:0]            dut_vec;

  int checks = 0;
  int errors = 0;

  noc_packet_collector #(.NODES(NODES), .PKT_W(PKT_W), .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_router(in_router), .key_next(key_next),
    .disp_valid(disp_valid), .fifo_count(fifo_count), .pkt_count(pkt_count),
    .lost_flag(lost_flag), .hex_data(hex_data), .hex_router(hex_router)
  );

  always #5 clk = ~clk;

  assign dut_vec = {fifo_count, pkt_count, lost_flag, disp_valid, hex_data, hex_router};

  // Reference model: per-slot history, pending table, queue FIFO, display state.
  logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  bit         m_v1 [NODES];
  bit         m_v2 [NODES];
  int         m_in_pay [NODES];
  bit         m_pend [NODES];
  int         m_pay [NODES];
  int         m_rr, m_pkt, m_disp_idx, m_disp_pay;
  bit         m_lost, m_key, m_disp_valid;
  logic [6:0] m_hex_data, m_hex_router;
  int         q_idx [$];
  int         q_pay [$];

  function automatic logic [6:0] seg_of(input int v);
    if (v <= 9) return ~seg_tbl[v];
    return DASH;
  endfunction

  function automatic logic [26:0] exp_vec();
    return {3'(q_idx.size()), 8'(m_pkt), m_lost, m_disp_valid, m_hex_data, m_hex_router};
  endfunction

  task automatic model_step();
    bit pop, found, grant, arr;
    int gj;
    if (reset) begin
      for (int i = 0; i < NODES; i++) begin
        m_v1[i] = 0; m_v2[i] = 0; m_pend[i] = 0; m_pay[i] = 0; m_in_pay[i] = 0;
      end
      m_rr = 0; m_pkt = 0; m_lost = 0; m_key = 0; m_disp_valid = 0;
      m_disp_idx = 0; m_disp_pay = 0; m_hex_data = BLANK; m_hex_router = BLANK;
      q_idx.delete(); q_pay.delete();
      return;
    end
    pop = key_next && !m_key && (q_idx.size() > 0);
    found = 0; gj = 0;
    for (int k = 0; k < NODES; k++) begin
      int j;
      j = (m_rr + k) % NODES;
      if (!found && m_pend[j]) begin found = 1; gj = j; end
    end
    grant = found && ((q_idx.size() < FIFO_DEPTH) || pop);
    m_hex_data   = m_disp_valid ? seg_of(m_disp_pay % 128) : BLANK;
    m_hex_router = m_disp_valid ? seg_of(m_disp_idx) : BLANK;
    if (pop) begin
      m_disp_idx = q_idx.pop_front();
      m_disp_pay = q_pay.pop_front();
      m_disp_valid = 1;
    end
    if (grant) begin
      q_idx.push_back(gj);
      q_pay.push_back(m_pay[gj]);
      m_rr = (gj + 1) % NODES;
      if (m_pkt < 255) m_pkt++;
    end
    for (int i = 0; i < NODES; i++) begin
      arr = m_v1[i] && !m_v2[i];
      if (grant && gj == i) m_pend[i] = 0;
      if (arr) begin
        if (m_pend[i]) m_lost = 1;
        m_pend[i] = 1;
        m_pay[i] = m_in_pay[i];
      end
      m_v2[i] = m_v1[i];
      m_v1[i] = in_router[i*PKT_W + PKT_W - 1];
      m_in_pay[i] = int'(in_router[i*PKT_W +: PKT_W-1]);
    end
    m_key = key_next;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_slot(input int s, input bit v, input int pay);
    in_router[s*PKT_W +: PKT_W] = {v, 14'(pay)};
  endtask

  task automatic press_key();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_router = '0;
    key_next = 1'b0;
    reset = 1'b1;
    ticks(2);
    checks++;
    if (dut_vec !== {3'd0, 8'd0, 1'b0, 1'b0, BLANK, BLANK}) begin
      errors++; $display("[TB] FAIL reset_state: got %h expected %h", dut_vec, {3'd0, 8'd0, 1'b0, 1'b0, BLANK, BLANK});
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_slot(3, 1'b1, 5);
    tick();
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++; $display("[TB] FAIL single_early_count: got %0d expected 0", fifo_count);
    end
    ticks(3);
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("[TB] FAIL single_count: got %0d expected 1", fifo_count);
    end
    press_key();
    checks++;
    if ({disp_valid, hex_router, hex_data} !== {1'b1, ~7'b1111001, ~7'b1011011}) begin
      errors++; $display("[TB] FAIL single_display: got %b_%b_%b expected 1_%b_%b",
                         disp_valid, hex_router, hex_data, ~7'b1111001, ~7'b1011011);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL single_model: got %h expected %h", dut_vec, exp_vec());
    end
    set_slot(3, 1'b0, 0);
    ticks(2);
  endtask

  task automatic test_rr_order();
    logic [6:0] exp_d [5] = '{~7'b0110000, ~7'b1101101, ~7'b1111001, ~7'b1011111, ~7'b0110011};
    logic [6:0] exp_r [5] = '{~7'b1111110, DASH, DASH, DASH, ~7'b1111110};
    do_reset();
    set_slot(0, 1'b1, 1); set_slot(40, 1'b1, 2); set_slot(80, 1'b1, 3);
    ticks(8);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++; $display("[TB] FAIL rr_count: got %0d expected 3", fifo_count);
    end
    for (int p = 0; p < 3; p++) begin
      press_key();
      checks++;
      if ({hex_router, hex_data} !== {exp_r[p], exp_d[p]}) begin
        errors++; $display("[TB] FAIL rr_order_%0d: got %b_%b expected %b_%b", p, hex_router, hex_data, exp_r[p], exp_d[p]);
      end
    end
    in_router = '0;
    ticks(3);
    set_slot(0, 1'b1, 7);
    ticks(5);
    press_key();
    in_router = '0;
    ticks(3);
    set_slot(0, 1'b1, 4); set_slot(80, 1'b1, 6);
    ticks(5);
    for (int p = 3; p < 5; p++) begin
      press_key();
      checks++;
      if ({hex_router, hex_data} !== {exp_r[p], exp_d[p]}) begin
        errors++; $display("[TB] FAIL rr_wrap_%0d: got %b_%b expected %b_%b", p, hex_router, hex_data, exp_r[p], exp_d[p]);
      end
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL rr_model: got %h expected %h", dut_vec, exp_vec());
    end
    in_router = '0;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 5; k++) set_slot(10 + k, 1'b1, k + 1);
    ticks(12);
    checks++;
    if ({fifo_count, pkt_count, lost_flag} !== {3'd4, 8'd4, 1'b0}) begin
      errors++; $display("[TB] FAIL full_hold: got %0d/%0d/%0d expected 4/4/0", fifo_count, pkt_count, lost_flag);
    end
    press_key();
    checks++;
    if ({fifo_count, pkt_count, hex_data} !== {3'd4, 8'd5, ~7'b0110000}) begin
      errors++; $display("[TB] FAIL full_pop: got %0d/%0d/%b expected 4/5/%b", fifo_count, pkt_count, hex_data, ~7'b0110000);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL full_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_lost();
    set_slot(7, 1'b1, 8);
    ticks(3);
    set_slot(7, 1'b0, 0);
    ticks(3);
    set_slot(7, 1'b1, 9);
    ticks(3);
    checks++;
    if ({lost_flag, pkt_count, fifo_count} !== {1'b1, 8'd5, 3'd4}) begin
      errors++; $display("[TB] FAIL lost_flag: got %0d/%0d/%0d expected 1/5/4", lost_flag, pkt_count, fifo_count);
    end
    press_key();
    checks++;
    if ({pkt_count, fifo_count, lost_flag} !== {8'd6, 3'd4, 1'b1}) begin
      errors++; $display("[TB] FAIL lost_recover: got %0d/%0d/%0d expected 6/4/1", pkt_count, fifo_count, lost_flag);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL lost_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_key_hold();
    in_router = '0;
    do_reset();
    set_slot(15, 1'b1, 12); set_slot(20, 1'b1, 1); set_slot(21, 1'b1, 2);
    ticks(8);
    key_next = 1'b1;
    ticks(20);
    checks++;
    if ({fifo_count, disp_valid, hex_data, hex_router} !== {3'd2, 1'b1, DASH, DASH}) begin
      errors++; $display("[TB] FAIL key_hold: got %0d/%0d/%b/%b expected 2/1/%b/%b",
                         fifo_count, disp_valid, hex_data, hex_router, DASH, DASH);
    end
    key_next = 1'b0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL key_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    in_router = '0;
    set_slot(50, 1'b1, 3);
    ticks(5);
    checks++;
    if ({fifo_count, disp_valid} !== {3'd3, 1'b1}) begin
      errors++; $display("[TB] FAIL mid_pre: got %0d/%0d expected 3/1", fifo_count, disp_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dut_vec !== {3'd0, 8'd0, 1'b0, 1'b0, BLANK, BLANK}) begin
      errors++; $display("[TB] FAIL mid_reset: got %h expected %h", dut_vec, {3'd0, 8'd0, 1'b0, 1'b0, BLANK, BLANK});
    end
    reset = 1'b0;
    ticks(6);
    checks++;
    if ({fifo_count, pkt_count} !== {3'd1, 8'd1}) begin
      errors++; $display("[TB] FAIL mid_recapture: got %0d/%0d expected 1/1", fifo_count, pkt_count);
    end
    ticks(10);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL mid_model: got %h expected %h", dut_vec, exp_vec());
    end
    in_router = '0;
  endtask

  task automatic test_random();
    int s, pay;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 2) == 0) begin
          s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, NODES - 1));
          pay = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 16383));
          set_slot(s, ~in_router[s*PKT_W + PKT_W - 1], pay);
        end
      end
      key_next = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 249) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("[TB] FAIL random_cycle_%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    reset = 1'b0;
    key_next = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_full();
    test_lost();
    test_key_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
